imem_arbiter: RTL and testbench

Sequencer and arbiter for the 32x32 instruction memory, shared between the processor fetch stage (read-only) and a boot/debug loader (write). Fetch owns the memory by default. A loader session takes the port through a guarded hand-over, writes words, and returns it. The block drives the memory's address, write-enable and write-data pins, and registers fetched words for the fetch stage.

---
 rtl/imem_arbiter_if.sv | 44 ++++
 rtl/imem_arbiter.sv | 89 ++++++++
 tb/tb_imem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, the fetch stage,
// the boot/debug loader and the 32x32 instruction memory.
//
// Handshake: a fetch is taken on a rising edge where f_req=1 and f_stall=0;
// its word appears on f_data with f_valid=1 after that edge. A loader beat
// is taken on a rising edge where ld_valid=1 and ld_ready=1; ld_last is
// only meaningful on such a beat. ld_req must stay high for the whole
// session; dropping it while ld_ready=1 ends the session.
interface imem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_stall;
    logic              f_valid;
    logic [DATA_W-1:0] f_data;
    logic              ld_req;
    logic              ld_valid;
    logic              ld_last;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [ADDR_W:0]   ld_count;
    logic              ld_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side: owns the memory pins and the fetch/loader responses.
    modport master (
        input  f_req, f_addr, ld_req, ld_valid, ld_last, ld_addr, ld_data, mem_rdata,
        output f_stall, f_valid, f_data, ld_ready, ld_count, ld_done,
        mem_addr, mem_we, mem_wdata
    );

    // Environment side: fetch stage, loader and the memory itself.
    modport slave (
        output f_req, f_addr, ld_req, ld_valid, ld_last, ld_addr, ld_data, mem_rdata,
        input  f_stall, f_valid, f_data, ld_ready, ld_count, ld_done,
        mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction-memory sequencer: fetch owns the port by default, a loader
// session takes it through a one-cycle guard, writes words, and hands it
// back through a one-cycle release. Fetched words are registered.
module imem_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int AUTO_INC = 0
) (
    input  logic        clk,
    input  logic        reset,
    imem_arbiter_if.master bus,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_GUARD   = 2'd1,
        S_LOAD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   count;
    logic              fv_q;
    logic [DATA_W-1:0] fd_q;
    logic              beat;
    logic              fetch_ok;

    // Handshake qualifiers decoded from state so reset silences them at once.
    always_comb begin
        beat     = (state == S_LOAD) && bus.ld_valid;
        fetch_ok = (state == S_FETCH) && bus.f_req && !bus.ld_req;
    end

    // Memory pins and handshake responses, all decoded from state.
    always_comb begin
        bus.mem_we    = beat;
        bus.mem_wdata = bus.ld_data;
        bus.mem_addr  = bus.f_addr;
        if (beat)
            bus.mem_addr = (AUTO_INC != 0) ? ptr : bus.ld_addr;
        bus.f_stall   = (state != S_FETCH) || bus.ld_req;
        bus.ld_ready  = (state == S_LOAD);
        bus.ld_done   = (state == S_RELEASE);
        bus.ld_count  = count;
        bus.f_valid   = fv_q;
        bus.f_data    = fd_q;
        dbg_state     = state;
    end

    // Ownership sequencing, loader bookkeeping and the fetch data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            ptr   <= '0;
            count <= '0;
            fv_q  <= 1'b0;
            fd_q  <= '0;
        end else begin
            fv_q <= fetch_ok;
            if (fetch_ok)
                fd_q <= bus.mem_rdata;
            case (state)
                S_FETCH: begin
                    if (bus.ld_req)
                        state <= S_GUARD;
                end
                S_GUARD: begin
                    count <= '0;
                    ptr   <= '0;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    if (beat) begin
                        // count saturates at 2^ADDR_W, the MSB alone marks it
                        if (!count[ADDR_W])
                            count <= count + 1'b1;
                        ptr <= ptr + 1'b1;
                    end
                    // a beat still lands when ld_req drops with ld_valid high
                    if ((beat && bus.ld_last) || !bus.ld_req)
                        state <= S_RELEASE;
                end
                S_RELEASE: state <= S_FETCH;
                default:   state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: two instances (explicit address and auto-increment)
// share clock, reset and stimulus; each has its own memory and reference model.
module tb_imem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;

    imem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) if0 ();
    imem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) if1 ();
    logic [1:0] st0, st1;

    imem_arbiter #(.ADDR_W(5), .DATA_W(32), .AUTO_INC(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.master), .dbg_state(st0));
    imem_arbiter #(.ADDR_W(5), .DATA_W(32), .AUTO_INC(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.master), .dbg_state(st1));

    // clock
    always #5 clk = ~clk;

    // memories: combinational read, write on rising edge
    logic [31:0] mem0 [32];
    logic [31:0] mem1 [32];
    assign if0.mem_rdata = mem0[if0.mem_addr];
    assign if1.mem_rdata = mem1[if1.mem_addr];
    always @(posedge clk) if (if0.mem_we) mem0[if0.mem_addr] <= if0.mem_wdata;
    always @(posedge clk) if (if1.mem_we) mem1[if1.mem_addr] <= if1.mem_wdata;

    // outputs gathered so both instances are checked in one loop
    logic        o_stall [2], o_rdy [2], o_done [2], o_fv [2], o_we [2];
    logic [31:0] o_fd [2], o_wd [2];
    logic [4:0]  o_addr [2];
    logic [5:0]  o_cnt [2];
    logic [1:0]  o_st [2];
    assign o_stall[0] = if0.f_stall;  assign o_stall[1] = if1.f_stall;
    assign o_rdy[0]   = if0.ld_ready; assign o_rdy[1]   = if1.ld_ready;
    assign o_done[0]  = if0.ld_done;  assign o_done[1]  = if1.ld_done;
    assign o_fv[0]    = if0.f_valid;  assign o_fv[1]    = if1.f_valid;
    assign o_we[0]    = if0.mem_we;   assign o_we[1]    = if1.mem_we;
    assign o_fd[0]    = if0.f_data;   assign o_fd[1]    = if1.f_data;
    assign o_wd[0]    = if0.mem_wdata; assign o_wd[1]   = if1.mem_wdata;
    assign o_addr[0]  = if0.mem_addr; assign o_addr[1]  = if1.mem_addr;
    assign o_cnt[0]   = if0.ld_count; assign o_cnt[1]   = if1.ld_count;
    assign o_st[0]    = st0;          assign o_st[1]    = st1;

    // current stimulus
    logic        in_freq, in_lreq, in_lval, in_llast;
    logic [4:0]  in_faddr, in_laddr;
    logic [31:0] in_ldat;

    // reference model: who owns the port, session bookkeeping, memory image
    localparam int P_FETCH = 0, P_GUARD = 1, P_LOAD = 2, P_REL = 3;
    int          ph [2];
    logic [5:0]  cnt [2];
    logic [4:0]  ptr [2];
    logic        fv [2];
    logic [31:0] fd [2];
    logic [31:0] mm [2][32];
    int          done_seen [2];
    logic        we_seen [2];

    int tot = 0;
    int bad = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = P_FETCH; cnt[k] = '0; ptr[k] = '0; fv[k] = 1'b0; fd[k] = '0;
        end
    endtask

    task automatic drive(input logic fr, input logic [4:0] fa, input logic lr, input logic lv,
                         input logic ll, input logic [4:0] la, input logic [31:0] ld);
        in_freq = fr; in_faddr = fa; in_lreq = lr; in_lval = lv; in_llast = ll;
        in_laddr = la; in_ldat = ld;
        if0.f_req = fr; if0.f_addr = fa; if0.ld_req = lr; if0.ld_valid = lv;
        if0.ld_last = ll; if0.ld_addr = la; if0.ld_data = ld;
        if1.f_req = fr; if1.f_addr = fa; if1.ld_req = lr; if1.ld_valid = lv;
        if1.ld_last = ll; if1.ld_addr = la; if1.ld_data = ld;
    endtask

    // compare every output of both instances with the model, mid-cycle
    task automatic sample();
        logic beat;
        logic [4:0] ea;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            beat = (ph[k] == P_LOAD) && in_lval;
            ea = !beat ? in_faddr : (k == 1 ? ptr[k] : in_laddr);
            chk("f_stall", k, 32'(o_stall[k]), 32'(ph[k] != P_FETCH || in_lreq));
            chk("ld_ready", k, 32'(o_rdy[k]), 32'(ph[k] == P_LOAD));
            chk("ld_done", k, 32'(o_done[k]), 32'(ph[k] == P_REL));
            chk("mem_we", k, 32'(o_we[k]), 32'(beat));
            chk("mem_addr", k, 32'(o_addr[k]), 32'(ea));
            if (beat) chk("mem_wdata", k, o_wd[k], in_ldat);
            chk("f_valid", k, 32'(o_fv[k]), 32'(fv[k]));
            chk("f_data", k, o_fd[k], fd[k]);
            chk("ld_count", k, 32'(o_cnt[k]), 32'(cnt[k]));
            chk("state", k, 32'(o_st[k]), 32'(ph[k]));
            if (o_done[k]) done_seen[k]++;
            if (o_we[k]) we_seen[k] = 1'b1;
        end
    endtask

    // clock edge: advance the model with the inputs that were present
    task automatic advance();
        logic beat;
        logic [4:0] wa;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            beat = (ph[k] == P_LOAD) && in_lval;
            fv[k] = (ph[k] == P_FETCH) && in_freq && !in_lreq;
            if (fv[k]) fd[k] = mm[k][in_faddr];
            case (ph[k])
                P_FETCH: if (in_lreq) ph[k] = P_GUARD;
                P_GUARD: begin cnt[k] = '0; ptr[k] = '0; ph[k] = P_LOAD; end
                P_LOAD: begin
                    if (beat) begin
                        wa = (k == 1) ? ptr[k] : in_laddr;
                        mm[k][wa] = in_ldat;
                        if (cnt[k] < 6'd32) cnt[k] = cnt[k] + 6'd1;
                        ptr[k] = ptr[k] + 5'd1;
                    end
                    if ((beat && in_llast) || !in_lreq) ph[k] = P_REL;
                end
                default: ph[k] = P_FETCH;
            endcase
        end
        #1;
    endtask

    task automatic cycle(input logic fr, input logic [4:0] fa, input logic lr, input logic lv,
                         input logic ll, input logic [4:0] la, input logic [31:0] ld);
        drive(fr, fa, lr, lv, ll, la, ld);
        sample();
        advance();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst f_valid", k, 32'(o_fv[k]), 32'h0);
            chk("rst f_data", k, o_fd[k], 32'h0);
            chk("rst ld_count", k, 32'(o_cnt[k]), 32'h0);
            chk("rst ld_done", k, 32'(o_done[k]), 32'h0);
            chk("rst mem_we", k, 32'(o_we[k]), 32'h0);
            chk("rst state", k, 32'(o_st[k]), 32'h0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // directed vectors with hand-derived expectations for the explicit-address instance
    typedef struct {
        logic fr; logic [4:0] fa; logic lr; logic lv; logic ll; logic [4:0] la; logic [31:0] ld;
        logic es; logic er; logic ed; logic efv; logic [31:0] efd; logic [5:0] ecnt;
    } vec_t;
    vec_t tbl [11];

    function automatic vec_t v(logic fr, logic [4:0] fa, logic lr, logic lv, logic ll,
                               logic [4:0] la, logic [31:0] ld, logic es, logic er, logic ed,
                               logic efv, logic [31:0] efd, logic [5:0] ecnt);
        vec_t r;
        r.fr = fr; r.fa = fa; r.lr = lr; r.lv = lv; r.ll = ll; r.la = la; r.ld = ld;
        r.es = es; r.er = er; r.ed = ed; r.efv = efv; r.efd = efd; r.ecnt = ecnt;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic lr_hold;
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 32'hA0 + 32'(i);
            mem1[i] = 32'hA0 + 32'(i);
            mm[0][i] = 32'hA0 + 32'(i);
            mm[1][i] = 32'hA0 + 32'(i);
        end
        for (int k = 0; k < 2; k++) begin done_seen[k] = 0; we_seen[k] = 1'b0; end
        do_reset();

        // fetch 0,1,2 back to back, then hand-over with colliding fetch, one write to 7
        tbl[0]  = v(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'd0);
        tbl[1]  = v(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hA0,       6'd0);
        tbl[2]  = v(1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hA1,       6'd0);
        tbl[3]  = v(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hA2,       6'd0);
        tbl[4]  = v(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hA2,       6'd0);
        tbl[5]  = v(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hA2,       6'd0);
        tbl[6]  = v(1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA2,       6'd0);
        tbl[7]  = v(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hA2,       6'd1);
        tbl[8]  = v(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hA2,       6'd1);
        tbl[9]  = v(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 6'd1);
        tbl[10] = v(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 6'd1);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].fr, tbl[i].fa, tbl[i].lr, tbl[i].lv, tbl[i].ll, tbl[i].la, tbl[i].ld);
            sample();
            chk("tbl f_stall", 0, 32'(o_stall[0]), 32'(tbl[i].es));
            chk("tbl ld_ready", 0, 32'(o_rdy[0]), 32'(tbl[i].er));
            chk("tbl ld_done", 0, 32'(o_done[0]), 32'(tbl[i].ed));
            chk("tbl f_valid", 0, 32'(o_fv[0]), 32'(tbl[i].efv));
            chk("tbl f_data", 0, o_fd[0], tbl[i].efd);
            chk("tbl ld_count", 0, 32'(o_cnt[0]), 32'(tbl[i].ecnt));
            advance();
        end

        // 33-beat session: addresses wrap, count saturates at 32
        for (int k = 0; k < 2; k++) done_seen[k] = 0;
        cycle(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 33; i++)
            cycle(1'b0, 5'd0, 1'b1, 1'b1, (i == 32), 5'(i), 32'h100 + 32'(i));
        cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            chk("sat ld_count", k, 32'(o_cnt[k]), 32'd32);
            chk("sat done pulses", k, 32'(done_seen[k]), 32'd1);
        end
        cycle(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            chk("wrap f_valid", k, 32'(o_fv[k]), 32'h1);
            chk("wrap f_data", k, o_fd[k], 32'h120);
        end

        // abort: ld_req drops in LOAD with no beat
        for (int k = 0; k < 2; k++) we_seen[k] = 1'b0;
        cycle(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 2; k++) chk("abort release", k, 32'(o_st[k]), 32'd3);
        cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            chk("abort fetch", k, 32'(o_st[k]), 32'd0);
            chk("abort ld_count", k, 32'(o_cnt[k]), 32'd0);
            chk("abort no write", k, 32'(we_seen[k]), 32'd0);
        end

        // reset in the middle of a LOAD beat to address 3
        cycle(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h55555555);
        #2;
        for (int k = 0; k < 2; k++) chk("beat before rst", k, 32'(o_we[k]), 32'h1);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst mid we", k, 32'(o_we[k]), 32'h0);
            chk("rst mid ready", k, 32'(o_rdy[k]), 32'h0);
            chk("rst mid state", k, 32'(o_st[k]), 32'h0);
            chk("rst mid f_valid", k, 32'(o_fv[k]), 32'h0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        cycle(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            chk("post rst f_valid", k, 32'(o_fv[k]), 32'h1);
            chk("post rst keep", k, o_fd[k], 32'h103);
        end

        // randomized traffic against the model
        lr_hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!lr_hold) lr_hold = ($urandom_range(0, 9) == 0);
            else lr_hold = ($urandom_range(0, 19) != 0);
            cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), lr_hold,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  5'($urandom_range(0, 31)), $urandom);
        end
        cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
